// File: rtl/gpr_pkg.sv
// Shared widths, FSM states and lane/warp data types for the GPR read responder.
package gpr_pkg;
  localparam int NUM_WARPS   = 4;
  localparam int NUM_REGS    = 32;
  localparam int NUM_THREADS = 4;
  localparam int XLEN        = 32;

  localparam int WB    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int RB    = $clog2(NUM_REGS);
  localparam int AW    = WB + RB;
  localparam int DEPTH = NUM_WARPS * NUM_REGS;

  typedef enum logic [1:0] {IDLE, RS3, SWEEP} gpr_state_e;

  typedef logic [XLEN-1:0] lane_t;
  typedef lane_t [NUM_THREADS-1:0] warp_data_t;
endpackage

// File: rtl/gpr_bank_ram.sv
// Warp-wide register bank: two synchronous read ports, one lane-masked write port,
// with write-to-read bypass so a same-cycle read sees the masked lanes being written.
module gpr_bank_ram
  import gpr_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd_en_a,
  input  logic [AW-1:0]          rd_addr_a,
  input  logic                   rd_zero_a,
  output warp_data_t             rd_data_a,
  input  logic                   rd_en_b,
  input  logic [AW-1:0]          rd_addr_b,
  input  logic                   rd_zero_b,
  output warp_data_t             rd_data_b,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [NUM_THREADS-1:0] wr_mask,
  input  warp_data_t             wr_data
);
  warp_data_t mem [DEPTH];

  // rd_zero forces the architectural zero register regardless of stored contents.
  function automatic warp_data_t read_word(input logic [AW-1:0] addr, input logic zero);
    warp_data_t d;
    d = mem[addr];
    if (wr_en && (wr_addr == addr)) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (wr_mask[i]) d[i] = wr_data[i];
      end
    end
    if (zero) d = '0;
    return d;
  endfunction

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (wr_en && wr_mask[i]) mem[wr_addr][i] <= wr_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      if (rd_en_a) rd_data_a <= read_word(rd_addr_a, rd_zero_a);
      if (rd_en_b) rd_data_b <= read_word(rd_addr_b, rd_zero_b);
    end
  end
endmodule

// File: rtl/gpr_read_responder.sv
// GPR request slave: reads rs1/rs2 on accept, rs3 one cycle later, returns data on a valid/ready port.
// Optional GPR_RESET_EN: zero-fill sweep of every (warp, reg) entry after reset.
module gpr_read_responder
  import gpr_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic [WB-1:0]                 req_wid,
  input  logic [RB-1:0]                 req_rs1,
  input  logic [RB-1:0]                 req_rs2,
  input  logic [RB-1:0]                 req_rs3,
  input  logic                          req_use_rs3,
  output logic                          req_ready,
  output logic                          rsp_valid,
  output logic [WB-1:0]                 rsp_wid,
  output logic [NUM_THREADS*XLEN-1:0]   rsp_rs1_data,
  output logic [NUM_THREADS*XLEN-1:0]   rsp_rs2_data,
  output logic [NUM_THREADS*XLEN-1:0]   rsp_rs3_data,
  input  logic                          rsp_ready,
  input  logic                          wb_valid,
  input  logic [WB-1:0]                 wb_wid,
  input  logic [RB-1:0]                 wb_rd,
  input  logic [NUM_THREADS-1:0]        wb_tmask,
  input  logic [NUM_THREADS*XLEN-1:0]   wb_data
);
  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // response payload is held stable while rsp_valid && !rsp_ready.
  gpr_state_e       state;
  logic             rsp_three;
  logic [WB-1:0]    pend_wid;
  logic [RB-1:0]    pend_rs3;
  warp_data_t       stage_rs1;
  warp_data_t       ram_a;
  warp_data_t       ram_b;
  logic             accept;
  logic             rd_en_a;
  logic [AW-1:0]    rd_addr_a;
  logic             rd_zero_a;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [NUM_THREADS-1:0] wr_mask;
  warp_data_t       wr_data;
`ifdef GPR_RESET_EN
  logic [AW-1:0]    sweep_cnt;
`endif

  assign req_ready = (state == IDLE) && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  // Port A is shared: rs1 on accept, rs3 in the RS3 cycle.
  assign rd_en_a   = accept || (state == RS3);
  assign rd_addr_a = (state == RS3) ? {pend_wid, pend_rs3} : {req_wid, req_rs1};
  assign rd_zero_a = (state == RS3) ? (pend_rs3 == '0) : (req_rs1 == '0);

  always_comb begin
    wr_en   = wb_valid && (wb_rd != '0);
    wr_addr = {wb_wid, wb_rd};
    wr_mask = wb_tmask;
    wr_data = wb_data;
`ifdef GPR_RESET_EN
    if (state == SWEEP) begin
      wr_en   = 1'b1;
      wr_addr = sweep_cnt;
      wr_mask = '1;
      wr_data = '0;
    end
`endif
  end

  gpr_bank_ram u_bank (
    .clk       (clk),
    .reset     (reset),
    .rd_en_a   (rd_en_a),
    .rd_addr_a (rd_addr_a),
    .rd_zero_a (rd_zero_a),
    .rd_data_a (ram_a),
    .rd_en_b   (accept),
    .rd_addr_b ({req_wid, req_rs2}),
    .rd_zero_b (req_rs2 == '0),
    .rd_data_b (ram_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_mask   (wr_mask),
    .wr_data   (wr_data)
  );

  // For 3-operand responses port A holds rs3, so rs1 comes from the stage register.
  assign rsp_rs1_data = rsp_three ? stage_rs1 : ram_a;
  assign rsp_rs2_data = ram_b;
  assign rsp_rs3_data = rsp_three ? ram_a : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef GPR_RESET_EN
      state     <= SWEEP;
      sweep_cnt <= '0;
`else
      state     <= IDLE;
`endif
      rsp_valid <= 1'b0;
      rsp_wid   <= '0;
      rsp_three <= 1'b0;
      pend_wid  <= '0;
      pend_rs3  <= '0;
      stage_rs1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_three <= req_use_rs3;
            pend_wid  <= req_wid;
            pend_rs3  <= req_rs3;
            if (req_use_rs3) begin
              state     <= RS3;
              rsp_valid <= 1'b0;
            end else begin
              rsp_valid <= 1'b1;
              rsp_wid   <= req_wid;
            end
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        RS3: begin
          state     <= IDLE;
          stage_rs1 <= ram_a;
          rsp_valid <= 1'b1;
          rsp_wid   <= pend_wid;
        end
        SWEEP: begin
`ifdef GPR_RESET_EN
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == AW'(DEPTH - 1)) state <= IDLE;
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && req_valid) assert (int'(req_wid) < NUM_WARPS);
    if (!reset && wb_valid) assert (int'(wb_wid) < NUM_WARPS);
  end
endmodule
